adc_clock_supervisor: RTL and testbench

Control-domain companion to the ADC LVDS MMCM clock generator. Sequences the MMCM reset, qualifies lock with a stability window, and drives the MMCM fine phase-shift port (PSEN/PSINCDEC/PSDONE) to walk the ADC sampling phase to a signed target in single steps. On loss of lock it restarts the MMCM and automatically re-applies the stored phase target. Sits between the MMCM instance and the ADC deserialiser/host register file.

---
 rtl/adc_clock_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_adc_clock_supervisor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_clock_supervisor.sv
// MMCM supervisor: reset sequencing, lock qualification and fine phase-shift walk to a signed target.
// Optional PSDONE watchdog enabled by defining ADC_PS_TIMEOUT_EN.
module adc_clock_supervisor #(
    parameter int RST_CYCLES  = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int PHASE_W     = 12,
    parameter int PS_TIMEOUT  = 64,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mmcm_locked,
    input  logic                      restart,
    input  logic signed [PHASE_W-1:0] phase_target,
    input  logic                      phase_load,
    input  logic                      ps_done,
    output logic                      mmcm_rst,
    output logic                      ps_en,
    output logic                      ps_incdec,
    output logic signed [PHASE_W-1:0] phase_current,
    output logic                      phase_busy,
    output logic                      clk_ready,
    output logic [CNT_W-1:0]          relock_count,
    output logic                      err_timeout
);

    localparam logic [2:0] RST_MMCM  = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] IDLE      = 3'd3;
    localparam logic [2:0] PS_PULSE  = 3'd4;
    localparam logic [2:0] PS_WAIT   = 3'd5;

    // One shared counter serves reset hold, lock qualification and the PSDONE watchdog.
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int CNT_MAX   = (CNT_MAX_A > PS_TIMEOUT) ? CNT_MAX_A : PS_TIMEOUT;
    localparam int TW        = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] CNT_ONE     = TW'(1);

    logic [2:0]                state;
    logic [TW-1:0]             cnt;
    logic                      lock_meta;
    logic                      lock_sync;
    logic signed [PHASE_W-1:0] target_q;
    logic                      at_target;
    logic                      lock_lost;

    // NOTE: non-blocking assignments make these two flops a true two-stage synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
        end
    end

    // The stored target survives restarts so the phase is re-applied after relock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
        end else if (phase_load) begin
            target_q <= phase_target;
        end
    end

    assign at_target  = (phase_current == target_q);
    assign lock_lost  = !lock_sync && (state == IDLE || state == PS_PULSE || state == PS_WAIT);
    assign phase_busy = (state == PS_PULSE) || (state == PS_WAIT) || (state == IDLE && !at_target);

`ifdef ADC_PS_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST = TW'(PS_TIMEOUT - 1);
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RST_MMCM;
            cnt           <= '0;
            mmcm_rst      <= 1'b1;
            ps_en         <= 1'b0;
            ps_incdec     <= 1'b0;
            phase_current <= '0;
            clk_ready     <= 1'b0;
            relock_count  <= '0;
`ifdef ADC_PS_TIMEOUT_EN
            err_timeout   <= 1'b0;
`endif
        end else begin
            ps_en     <= 1'b0;
            clk_ready <= 1'b0;
            // An explicit restart outranks a simultaneous lock loss and is not counted.
            if (restart || lock_lost) begin
                state         <= RST_MMCM;
                cnt           <= '0;
                mmcm_rst      <= 1'b1;
                phase_current <= '0;
                if (!restart && relock_count != '1) begin
                    relock_count <= relock_count + CNT_W'(1);
                end
`ifdef ADC_PS_TIMEOUT_EN
                if (restart) begin
                    err_timeout <= 1'b0;
                end
`endif
            end else begin
                case (state)
                    RST_MMCM: begin
                        mmcm_rst      <= 1'b1;
                        phase_current <= '0;
                        if (cnt == RST_LAST) begin
                            state    <= WAIT_LOCK;
                            mmcm_rst <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_sync) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end
                    end
                    STABLE: begin
                        if (!lock_sync) begin
                            state <= WAIT_LOCK;
                        end else if (cnt == STABLE_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    IDLE: begin
                        if (!at_target) begin
                            state     <= PS_PULSE;
                            ps_en     <= 1'b1;
                            ps_incdec <= (target_q > phase_current);
                            cnt       <= '0;
                        end else begin
                            clk_ready <= 1'b1;
                        end
                    end
                    PS_PULSE: begin
                        state <= PS_WAIT;
`ifdef ADC_PS_TIMEOUT_EN
                        cnt   <= cnt + CNT_ONE;
`endif
                    end
                    PS_WAIT: begin
                        // The step taken is the one issued, even if the target moved meanwhile.
                        if (ps_done) begin
                            state         <= IDLE;
                            phase_current <= ps_incdec ? phase_current + PHASE_W'(1)
                                                       : phase_current - PHASE_W'(1);
`ifdef ADC_PS_TIMEOUT_EN
                        end else if (cnt == TO_LAST) begin
                            err_timeout   <= 1'b1;
                            state         <= RST_MMCM;
                            cnt           <= '0;
                            mmcm_rst      <= 1'b1;
                            phase_current <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
`endif
                        end
                    end
                    default: begin
                        state    <= RST_MMCM;
                        cnt      <= '0;
                        mmcm_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_clock_supervisor.sv
// Self-checking bench for adc_clock_supervisor: vector table, hand sequences for lock corners,
// randomized phase walks against a step-count model of the MMCM phase shifter.
module tb_adc_clock_supervisor;

    localparam int RST_CYCLES  = 16;
    localparam int LOCK_STABLE = 8;
    localparam int PHASE_W     = 12;
    localparam int PS_TIMEOUT  = 64;
    localparam int CNT_W       = 8;

    typedef struct {
        int target;
        int delay;
        int pulses;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mmcm_locked = 1'b0;
    logic restart = 1'b0;
    logic signed [PHASE_W-1:0] phase_target = '0;
    logic phase_load = 1'b0;
    logic ps_done = 1'b0;

    logic mmcm_rst;
    logic ps_en;
    logic ps_incdec;
    logic signed [PHASE_W-1:0] phase_current;
    logic phase_busy;
    logic clk_ready;
    logic [CNT_W-1:0] relock_count;
    logic err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_en_cyc = -100;
    int pulse_cnt = 0;
    int model_phase = 0;
    int model_tgt = 0;
    int done_delay = 4;
    bit withhold = 1'b0;

    adc_clock_supervisor #(
        .RST_CYCLES (RST_CYCLES),
        .LOCK_STABLE(LOCK_STABLE),
        .PHASE_W    (PHASE_W),
        .PS_TIMEOUT (PS_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mmcm_locked  (mmcm_locked),
        .restart      (restart),
        .phase_target (phase_target),
        .phase_load   (phase_load),
        .ps_done      (ps_done),
        .mmcm_rst     (mmcm_rst),
        .ps_en        (ps_en),
        .ps_incdec    (ps_incdec),
        .phase_current(phase_current),
        .phase_busy   (phase_busy),
        .clk_ready    (clk_ready),
        .relock_count (relock_count),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int tgt);
        phase_target = PHASE_W'(tgt);
        phase_load   = 1'b1;
        model_tgt    = tgt;
        step();
        phase_load   = 1'b0;
    endtask

    task automatic settle(input string name);
        int n = 0;
        while (!(clk_ready === 1'b1 && phase_busy === 1'b0) && n < 30000) begin
            step();
            n++;
        end
        check({name, "_settle_in_time"}, n < 30000, 1);
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        int start;
        start      = pulse_cnt;
        done_delay = v.delay;
        load(v.target);
        step();
        check({name, "_ready_after_load"}, clk_ready, (v.pulses == 0));
        settle(name);
        check({name, "_pulses"}, pulse_cnt - start, v.pulses);
        check({name, "_phase"}, phase_current, v.target);
        check({name, "_busy_low"}, phase_busy, 0);
    endtask

    // MMCM phase-shift model: each PSEN moves the phase one step after done_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (ps_en === 1'b1) begin
                int dir;
                pulse_cnt++;
                check("ps_en_gap", (cyc - last_en_cyc) >= 3, 1);
                last_en_cyc = cyc;
                check("ps_incdec_dir", ps_incdec, (model_tgt > model_phase));
                check("phase_at_pulse", phase_current, model_phase);
                dir = (ps_incdec === 1'b1) ? 1 : -1;
                if (!withhold) begin
                    repeat (done_delay) @(negedge clk);
                    ps_done = 1'b1;
                    model_phase += dir;
                    @(negedge clk);
                    ps_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t tbl_a[2];
        vec_t tbl_b[6];
        int n;
        int r;
        bit seen_rst;
        bit seen_ready;

        tbl_a[0] = '{target: 3,  delay: 4, pulses: 3};
        tbl_a[1] = '{target: -2, delay: 2, pulses: 5};
        tbl_b[0] = '{target: -2,    delay: 3, pulses: 0};
        tbl_b[1] = '{target: 0,     delay: 1, pulses: 2};
        tbl_b[2] = '{target: 7,     delay: 3, pulses: 7};
        tbl_b[3] = '{target: 6,     delay: 1, pulses: 1};
        tbl_b[4] = '{target: -2048, delay: 1, pulses: 2054};
        tbl_b[5] = '{target: 2047,  delay: 1, pulses: 4095};

        // Reset values
        repeat (3) step();
        check("rst_mmcm_rst", mmcm_rst, 1);
        check("rst_ps_en", ps_en, 0);
        check("rst_ps_incdec", ps_incdec, 0);
        check("rst_phase", phase_current, 0);
        check("rst_busy", phase_busy, 0);
        check("rst_ready", clk_ready, 0);
        check("rst_relock", relock_count, 0);
        check("rst_err", err_timeout, 0);

        // Bring-up: mmcm_rst hold, then lock at cycle 20 and qualification
        reset = 1'b0;
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("mmcm_rst_hold_cycles", n, RST_CYCLES);
        repeat (20 - n) step();
        mmcm_locked = 1'b1;
        n = 20;
        while (clk_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("ready_cycle_window", (n >= 31 && n <= 33), 1);
        check("ready_phase_zero", phase_current, 0);
        check("ready_busy_low", phase_busy, 0);

        for (int i = 0; i < 2; i++) apply_vec($sformatf("vec_a%0d", i), tbl_a[i]);

        // Lock loss in IDLE at phase -2: restart, count, re-apply
        mmcm_locked = 1'b0;
        n = 0;
        while (mmcm_rst !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("lockloss_rst_seen", mmcm_rst, 1);
        check("lockloss_phase_cleared", phase_current, 0);
        check("lockloss_ready_low", clk_ready, 0);
        model_phase = 0;
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("lockloss_rst_cycles", n, RST_CYCLES);
        check("lockloss_relock_count", relock_count, 1);
        r = pulse_cnt;
        done_delay = 4;
        mmcm_locked = 1'b1;
        settle("relock");
        check("relock_pulses", pulse_cnt - r, 2);
        check("relock_phase", phase_current, -2);
        check("relock_incdec", ps_incdec, 0);

        // Restart, then a 3-cycle lock glitch while qualifying
        restart = 1'b1;
        mmcm_locked = 1'b0;
        step();
        restart = 1'b0;
        model_phase = 0;
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("restart_rst_cycles", n, RST_CYCLES);
        check("restart_no_count", relock_count, 1);
        r = pulse_cnt;
        mmcm_locked = 1'b1;
        repeat (5) step();
        mmcm_locked = 1'b0;
        repeat (3) step();
        mmcm_locked = 1'b1;
        seen_rst = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mmcm_rst !== 1'b0) seen_rst = 1'b1;
            if (clk_ready !== 1'b0) seen_ready = 1'b1;
        end
        check("glitch_no_restart", seen_rst, 0);
        check("glitch_requalify", seen_ready, 0);
        settle("glitch");
        check("glitch_relock_count", relock_count, 1);
        check("glitch_reapply_pulses", pulse_cnt - r, 2);
        check("glitch_phase", phase_current, -2);

        for (int i = 0; i < 6; i++) apply_vec($sformatf("vec_b%0d", i), tbl_b[i]);

        // Target changed mid-step at the positive limit: direction flips
        r = pulse_cnt;
        done_delay = 4;
        load(2044);
        n = 0;
        while (pulse_cnt == r && n < 20) begin
            step();
            n++;
        end
        load(2047);
        settle("midstep");
        check("midstep_pulses", pulse_cnt - r, 2);
        check("midstep_phase", phase_current, 2047);
        check("midstep_incdec", ps_incdec, 1);

        // Randomized walks against the step-count model
        for (int i = 0; i < 16; i++) begin
            int t;
            int exp_p;
            t = int'($urandom_range(0, 80)) - 40;
            exp_p = (t > model_phase) ? t - model_phase : model_phase - t;
            r = pulse_cnt;
            done_delay = int'($urandom_range(1, 6));
            load(t);
            repeat (int'($urandom_range(1, 3))) step();
            settle($sformatf("rand%0d", i));
            check($sformatf("rand%0d_pulses", i), pulse_cnt - r, exp_p);
            check($sformatf("rand%0d_phase", i), phase_current, t);
        end

`ifdef ADC_PS_TIMEOUT_EN
        withhold = 1'b1;
        r = int'(relock_count);
        load(model_phase + 1);
        n = 0;
        while (err_timeout !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("timeout_window", (n >= 60 && n <= 68), 1);
        check("timeout_restart", mmcm_rst, 1);
        check("timeout_no_count", relock_count, r);
        withhold = 1'b0;
        model_phase = 0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("timeout_cleared", err_timeout, 0);
`else
        check("err_timeout_idle", err_timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
